// File: rtl/stream_fifo.sv
// stream_fifo
//   First-word-fall-through FIFO backed by an inferred block RAM with a
//   registered read port. The registered RAM output is also the output stage.
//   DEPTH = 2**ADDR_WIDTH counts every stored word, including the one held in
//   the output register.
//
// Parameters
//   DATA_WIDTH   payload width
//   ADDR_WIDTH   log2 of total depth
//   AF_LEVEL     almost_full  when count >= AF_LEVEL
//   AE_LEVEL     almost_empty when count <= AE_LEVEL
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   s_valid/s_ready/s_data   write side handshake and payload
//   m_valid/m_ready/m_data   read side handshake and payload
//   flush                    synchronous clear of contents
//   clear_err                clears the sticky overflow flag (and the watermark)
//   count                    occupancy, 0..DEPTH
//   almost_full/almost_empty level flags decoded from count
//   overflow                 sticky: write attempted while s_ready=0
//   max_count                peak-occupancy watermark
//
// Build option
//   STREAM_FIFO_WATERMARK_EN  defined: max_count tracks peak occupancy.
//                             undefined: max_count is tied to zero.

module stream_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  input  logic                  clear_err,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   max_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra MSB so equal low bits can be told apart
  // (RAM empty vs. RAM holding DEPTH words).
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  overflow_q;

  logic ram_has_data;
  logic wr_en;
  logic rd_hs;
  logic rd_en;

  // s_ready depends only on registers and flush, never on s_valid.
  assign s_ready      = (count_q != FULL_CNT) && !flush;
  assign wr_en        = s_valid && s_ready;
  assign rd_hs        = m_valid_q && m_ready;
  assign ram_has_data = (wr_ptr != rd_ptr);
  // Refill the output register whenever it is empty or being drained.
  assign rd_en        = ram_has_data && (!m_valid_q || m_ready) && !flush;

  // Storage and registered read port; no reset so the RAM maps to a BRAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= s_data;
    end
    if (rd_en) begin
      m_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (rd_en) begin
        rd_ptr    <= rd_ptr + ONE;
        m_valid_q <= 1'b1;
      end else if (rd_hs) begin
        m_valid_q <= 1'b0;
      end
      case ({wr_en, rd_hs})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // A new overflow event takes priority over clear_err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (s_valid && !s_ready && !flush) begin
      overflow_q <= 1'b1;
    end else if (clear_err) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef STREAM_FIFO_WATERMARK_EN
  logic [ADDR_WIDTH:0] max_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_count_q <= '0;
    end else if (clear_err) begin
      max_count_q <= count_q;
    end else if (count_q > max_count_q) begin
      max_count_q <= count_q;
    end
  end

  assign max_count = max_count_q;
`else
  assign max_count = '0;
`endif

  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Testbench for stream_fifo (DATA_WIDTH=8, ADDR_WIDTH=4).
// Inputs are driven on the falling edge; the monitor samples 2 ns after the
// falling edge, directed checks sample 1 ns after the rising edge.

module tb_stream_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       flush;
  logic       clear_err;
  logic [4:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic [4:0] max_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, advanced on every rising edge from the driven inputs.
  logic [7:0] sb[$];
  int         cnt   = 0;
  int         ram_n = 0;
  bit         mv    = 1'b0;
  bit         ovf   = 1'b0;
  int         maxc  = 0;

  always #5 clk = ~clk;

  stream_fifo #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .AF_LEVEL  (14),
    .AE_LEVEL  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .flush       (flush),
    .clear_err   (clear_err),
    .count       (count),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .max_count   (max_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic step(input logic sv, input logic [7:0] sd, input logic mr,
                      input logic fl, input logic ce);
    @(negedge clk);
    s_valid   = sv;
    s_data    = sd;
    m_ready   = mr;
    flush     = fl;
    clear_err = ce;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    bit wr, rd, pf, room;
    if (!rst_n) begin
      cnt = 0; ram_n = 0; mv = 1'b0; ovf = 1'b0; maxc = 0;
      sb.delete();
    end else begin
      room = (cnt != 16) && !flush;
      wr   = s_valid && room;
      rd   = mv && m_ready && !flush;
      pf   = (ram_n > 0) && (!mv || m_ready) && !flush;
      if (s_valid && !room && !flush) ovf = 1'b1;
      else if (clear_err)            ovf = 1'b0;
`ifdef STREAM_FIFO_WATERMARK_EN
      if (clear_err)       maxc = cnt;
      else if (cnt > maxc) maxc = cnt;
`endif
      if (flush) begin
        cnt = 0; ram_n = 0; mv = 1'b0;
        sb.delete();
      end else begin
        if (wr) begin
          sb.push_back(s_data);
          ram_n++;
        end
        if (pf) begin
          ram_n--;
          mv = 1'b1;
        end else if (rd) begin
          mv = 1'b0;
        end
        cnt = cnt + int'(wr) - int'(rd);
      end
    end
  end

  // Monitor: per-cycle status compare and in-order data scoreboard.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      chk("count",        int'(count),        cnt);
      chk("m_valid",      int'(m_valid),      int'(mv));
      chk("s_ready",      int'(s_ready),      int'((cnt != 16) && !flush));
      chk("almost_full",  int'(almost_full),  int'(cnt >= 14));
      chk("almost_empty", int'(almost_empty), int'(cnt <= 2));
      chk("overflow",     int'(overflow),     int'(ovf));
      chk("max_count",    int'(max_count),    maxc);
      if (m_valid && m_ready && !flush) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got data 0x%0h expected no output at %0t", m_data, $time);
        end else begin
          chk("m_data", int'(m_data), int'(sb[0]));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    flush = 1'b0; clear_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_count",     int'(count),        0);
    chk("rst_m_valid",   int'(m_valid),      0);
    chk("rst_s_ready",   int'(s_ready),      1);
    chk("rst_overflow",  int'(overflow),     0);
    chk("rst_max_count", int'(max_count),    0);
    chk("rst_ae",        int'(almost_empty), 1);
    chk("rst_af",        int'(almost_full),  0);

    // Fill 0x01..0x10 with the consumer stalled, then drain.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 15) chk("t1_s_ready_15", int'(s_ready), 1);
    end
    chk("t1_count_full", int'(count),       16);
    chk("t1_s_ready",    int'(s_ready),     0);
    chk("t1_af",         int'(almost_full), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      chk("t1_drain_valid", int'(m_valid), 1);
      chk("t1_drain_data",  int'(m_data),  i);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("t1_count_empty", int'(count),   0);
    chk("t1_m_valid_end", int'(m_valid), 0);

    // Single word latency into an empty FIFO.
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t2_count_k",   int'(count),   1);
    chk("t2_valid_k",   int'(m_valid), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t2_valid_k1",  int'(m_valid), 1);
    chk("t2_data_k1",   int'(m_data),  8'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t2_count_rd",  int'(count),   0);
    chk("t2_valid_rd",  int'(m_valid), 0);

    // Streaming 100 words, pointers wrap several times.
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      if (i >= 1) begin
        chk("t3_count_steady", int'(count),   2);
        chk("t3_valid_steady", int'(m_valid), 1);
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t3_count_drained", int'(count), 0);

    // Overflow, full-with-read, clear and set-wins.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    chk("t4_count_full", int'(count), 16);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("t4_ovf_set",    int'(overflow), 1);
    chk("t4_count_ovf",  int'(count),    16);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk("t4_full_rd_cnt", int'(count),    15);
    chk("t4_ovf_hold",    int'(overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t4_ovf_clr",    int'(overflow), 0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    chk("t4_count_refill", int'(count),    16);
    chk("t4_ovf_noevent",  int'(overflow), 0);
    step(1'b1, 8'h88, 1'b0, 1'b0, 1'b1);
    chk("t4_ovf_setwins", int'(overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t4_ovf_sticky",  int'(overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t4_ovf_clr2",    int'(overflow), 0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_count_drained", int'(count), 0);

    // Flush while both sides handshake.
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    chk("t5_count5",  int'(count),   5);
    chk("t5_valid5",  int'(m_valid), 1);
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h99; m_ready = 1'b1; flush = 1'b1; clear_err = 1'b0;
    #1;
    chk("t5_s_ready_flush", int'(s_ready), 0);
    @(posedge clk);
    #1;
    chk("t5_count_flush", int'(count),    0);
    chk("t5_valid_flush", int'(m_valid),  0);
    chk("t5_ovf_flush",   int'(overflow), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t5_count_after", int'(count), 0);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t5_valid_3c", int'(m_valid), 1);
    chk("t5_data_3c",  int'(m_data),  8'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t5_count_end", int'(count), 0);

    // Watermark: fill to 9, drain to 2, clear.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t6_count2", int'(count), 2);
`ifdef STREAM_FIFO_WATERMARK_EN
    chk("t6_max_peak", int'(max_count), 9);
`else
    chk("t6_max_peak", int'(max_count), 0);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef STREAM_FIFO_WATERMARK_EN
    chk("t6_max_clr", int'(max_count), 2);
`else
    chk("t6_max_clr", int'(max_count), 0);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t6_count_end", int'(count), 0);

    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
